mul_seq_param: RTL and testbench

- Parametrised iterative shift-add multiplier for the MIPS datapath: multiplies two WIDTH-bit operands into a 2*WIDTH-bit product split into hi/lo halves.
- Supports signed (mult) and unsigned (multu) operation.
- Uses a start/busy/done handshake so the control unit can stall on it.
- Successor to the fixed 32-bit free-running multiplier: it has a defined latency, a handshake, a signed mode and a width parameter.

---
 rtl/mul_seq_param.sv | 107 ++++++++++
 tb/tb_mul_seq_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// mul_seq_param: iterative shift-add multiplier for the MIPS datapath.
// Takes one iteration per operand bit to form a 2*WIDTH-bit product, in signed
// (mult) or unsigned (multu) mode. The control unit stalls on a start/busy/done
// handshake.
//
// Ports
//   clk_sys        rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          request, sampled only in IDLE
//   op_signed      1 = two's-complement operands, 0 = unsigned (sampled with start)
//   multiplicando  operand A (sampled with start)
//   multiplicador  operand B (sampled with start)
//   busy           high while an operation is in flight
//   done           one-cycle pulse when hi/lo are updated
//   hi, lo         upper / lower halves of the product, held until the next result
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; hi/lo hold the last product
// RUN   | one shift-add step per cycle, WIDTH steps in total
// FIX   | apply sign to the magnitude product, publish hi/lo, pulse done
module mul_seq_param #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] multiplicando,
   input  logic [WIDTH-1:0] multiplicador,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic                 neg;
   logic [CNT_W-1:0]     cnt;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   prod;

   // The magnitude of the most negative value, 2^(WIDTH-1), still fits when the
   // operand is treated as unsigned, so no extra bit is needed.
   assign a_mag = (op_signed && multiplicando[WIDTH-1]) ? (~multiplicando + WIDTH'(1))
                                                        : multiplicando;
   assign b_mag = (op_signed && multiplicador[WIDTH-1]) ? (~multiplicador + WIDTH'(1))
                                                        : multiplicador;
   assign prod  = neg ? (~acc + (2*WIDTH)'(1)) : acc;

   // cnt counts down the remaining iterations; RUN ends on the cycle it is zero.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  neg    <= op_signed & (multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= CNT_W'(WIDTH - 1);
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            FIX: begin
               {hi, lo} <= prod;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq_param.sv
module tb_mul_seq_param;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;

   logic        start32 = 1'b0;
   logic        sgn32   = 1'b0;
   logic [31:0] a32     = '0;
   logic [31:0] b32     = '0;
   logic        busy32, done32;
   logic [31:0] hi32, lo32;

   logic        start8 = 1'b0;
   logic        sgn8   = 1'b0;
   logic [7:0]  a8     = '0;
   logic [7:0]  b8     = '0;
   logic        busy8, done8;
   logic [7:0]  hi8, lo8;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_sys = ~clk_sys;

   mul_seq_param #(.WIDTH(32)) dut32 (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start32), .op_signed(sgn32),
      .multiplicando(a32), .multiplicador(b32),
      .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
   );

   mul_seq_param #(.WIDTH(8)) dut8 (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start8), .op_signed(sgn8),
      .multiplicando(a8), .multiplicador(b8),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   // Counts edges from the current point until done32 is seen (-1 on timeout).
   task automatic wait_done32(output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk_sys); #1;
         if (done32) begin
            lat = k;
            break;
         end
         if (busy32) busy_cnt++;
      end
   endtask

   // Issues one start on dut32; lat counts edges from the start edge to the done edge.
   task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output int busy_cnt);
      int l, bc;
      @(negedge clk_sys);
      a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
      @(posedge clk_sys); #1;
      start32 = 1'b0;
      wait_done32(l, bc);
      lat = l;
      busy_cnt = bc + (busy32 ? 0 : 0) + 1;  // the E0 cycle is busy as well
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat);
      lat = -1;
      @(negedge clk_sys);
      a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
      @(posedge clk_sys); #1;
      start8 = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk_sys); #1;
         if (done8) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      n_checks++;
      if ({busy32, done32, hi32, lo32} !== 66'd0)
         $display("FAIL reset32 got busy=%b done=%b hi=%h lo=%h want all 0", busy32, done32, hi32, lo32);
      else n_pass++;
      n_checks++;
      if ({busy8, done8, hi8, lo8} !== 18'd0)
         $display("FAIL reset8 got busy=%b done=%b hi=%h lo=%h want all 0", busy8, done8, hi8, lo8);
      else n_pass++;
      @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   task automatic test_unsigned();
      int lat, bc;
      run32(32'd3, 32'd5, 1'b0, lat, bc);
      n_checks++;
      if (lat !== 33) $display("FAIL u_3x5_latency got %0d want 33", lat); else n_pass++;
      n_checks++;
      if (bc !== 33) $display("FAIL u_3x5_busy_cycles got %0d want 33", bc); else n_pass++;
      n_checks++;
      if (busy32 !== 1'b0) $display("FAIL u_3x5_busy_at_done got %b want 0", busy32); else n_pass++;
      n_checks++;
      if ({hi32, lo32} !== 64'h0000_0000_0000_000F)
         $display("FAIL u_3x5 got %h_%h want 00000000_0000000f", hi32, lo32);
      else n_pass++;
      @(posedge clk_sys); #1;
      n_checks++;
      if (done32 !== 1'b0) $display("FAIL done_pulse_width got %b want 0", done32); else n_pass++;
      n_checks++;
      if (lo32 !== 32'h0000_000F) $display("FAIL u_3x5_hold got %h want 0000000f", lo32); else n_pass++;

      run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
      n_checks++;
      if ({hi32, lo32} !== 64'hFFFF_FFFE_0000_0001)
         $display("FAIL u_max got %h_%h want fffffffe_00000001", hi32, lo32);
      else n_pass++;
   endtask

   task automatic test_signed();
      int lat, bc;
      run32(32'hFFFF_FFF9, 32'd3, 1'b1, lat, bc);
      n_checks++;
      if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFEB)
         $display("FAIL s_m7x3 got %h_%h want ffffffff_ffffffeb", hi32, lo32);
      else n_pass++;
      n_checks++;
      if (lat !== 33) $display("FAIL s_latency got %0d want 33", lat); else n_pass++;

      run32(32'h8000_0000, 32'h8000_0000, 1'b1, lat, bc);
      n_checks++;
      if ({hi32, lo32} !== 64'h4000_0000_0000_0000)
         $display("FAIL s_minxmin got %h_%h want 40000000_00000000", hi32, lo32);
      else n_pass++;

      run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bc);
      n_checks++;
      if ({hi32, lo32} !== 64'h0000_0000_0000_0001)
         $display("FAIL s_m1xm1 got %h_%h want 00000000_00000001", hi32, lo32);
      else n_pass++;

      run32(32'd0, 32'hFFFF_FFFB, 1'b1, lat, bc);
      n_checks++;
      if ({hi32, lo32} !== 64'd0)
         $display("FAIL s_zero_neg got %h_%h want 00000000_00000000", hi32, lo32);
      else n_pass++;
      n_checks++;
      if (lat !== 33) $display("FAIL s_zero_latency got %0d want 33", lat); else n_pass++;

      run32(32'h0001_2345, 32'hFFFF_FFFE, 1'b0, lat, bc);
      n_checks++;
      if ({hi32, lo32} !== 64'h0001_2344_FFFD_B976)
         $display("FAIL u_mixed got %h_%h want 00012344_fffdb976", hi32, lo32);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      @(negedge clk_sys);
      a32 = 32'd3; b32 = 32'd5; sgn32 = 1'b0; start32 = 1'b1;
      @(posedge clk_sys); #1;
      start32 = 1'b0;
      repeat (9) @(posedge clk_sys);
      @(negedge clk_sys);
      a32 = 32'd2; b32 = 32'd2; sgn32 = 1'b1; start32 = 1'b1;
      @(negedge clk_sys);
      start32 = 1'b0;
      wait_done32(lat, bc);
      lat = lat + 10;
      n_checks++;
      if (lat !== 33) $display("FAIL busy_start_latency got %0d want 33", lat); else n_pass++;
      n_checks++;
      if ({hi32, lo32} !== 64'd15)
         $display("FAIL busy_start_ignored got %h_%h want 00000000_0000000f", hi32, lo32);
      else n_pass++;
      // Raise start during the done cycle.
      a32 = 32'd2; b32 = 32'd2; sgn32 = 1'b0; start32 = 1'b1;
      @(posedge clk_sys); #1;
      start32 = 1'b0;
      n_checks++;
      if (busy32 !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy32); else n_pass++;
      wait_done32(lat, bc);
      n_checks++;
      if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else n_pass++;
      n_checks++;
      if ({hi32, lo32} !== 64'd4)
         $display("FAIL b2b_result got %h_%h want 00000000_00000004", hi32, lo32);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int lat, bc, seen;
      @(negedge clk_sys);
      a32 = 32'd3; b32 = 32'd5; sgn32 = 1'b0; start32 = 1'b1;
      @(posedge clk_sys); #1;
      start32 = 1'b0;
      repeat (11) @(posedge clk_sys);
      #3;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy32, done32, hi32, lo32} !== 66'd0)
         $display("FAIL mid_reset got busy=%b done=%b hi=%h lo=%h want all 0", busy32, done32, hi32, lo32);
      else n_pass++;
      @(negedge clk_sys);
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk_sys); #1;
         if (done32 || busy32) seen++;
      end
      n_checks++;
      if (seen !== 0) $display("FAIL mid_reset_no_done got %0d active cycles want 0", seen); else n_pass++;
      run32(32'd3, 32'd5, 1'b0, lat, bc);
      n_checks++;
      if (lat !== 33) $display("FAIL post_reset_latency got %0d want 33", lat); else n_pass++;
      n_checks++;
      if (lo32 !== 32'd15) $display("FAIL post_reset_result got %h want 0000000f", lo32); else n_pass++;
   endtask

   task automatic test_width8();
      int lat;
      run8(8'h80, 8'h7F, 1'b1, lat);
      n_checks++;
      if (lat !== 9) $display("FAIL w8_latency got %0d want 9", lat); else n_pass++;
      n_checks++;
      if ({hi8, lo8} !== 16'hC080) $display("FAIL w8_signed got %h_%h want c0_80", hi8, lo8); else n_pass++;
      run8(8'hFF, 8'hFF, 1'b0, lat);
      n_checks++;
      if ({hi8, lo8} !== 16'hFE01) $display("FAIL w8_unsigned got %h_%h want fe_01", hi8, lo8); else n_pass++;
      run8(8'hF9, 8'h03, 1'b1, lat);
      n_checks++;
      if ({hi8, lo8} !== 16'hFFEB) $display("FAIL w8_m7x3 got %h_%h want ff_eb", hi8, lo8); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_reset_mid_op();
      test_width8();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
